// File: rtl/wbs_ctrl.sv
// wbs_ctrl: Wishbone slave bridging the management bus (0x3xxx_xxxx) onto the
// accelerator's mode/debug registers, query-patch memory, banked leaf memory
// and internal-node memory. Wide memory words are accessed as 32-bit
// lower/upper halves; a lower-half write only fills a holding register, and
// the upper-half write commits the full word.
//
// Optional feature: define WBS_NODE_MEM_EN to map region 0x4 onto the node
// memory port. Without it, region 0x4 acks like an unmapped offset.
//
//   state  | meaning
//   IDLE   | waiting for a request; registers written, target latched
//   MEM    | selected memory strobed for one cycle (web low on commit)
//   WAIT   | read data from the 1-cycle SRAM sampled into wbs_dat_o
//   ACK    | wbs_ack_o high for one cycle
module wbs_ctrl #(
    parameter int DATA_WIDTH = 11,
    parameter int LEAF_SIZE  = 8,
    parameter int PATCH_SIZE = 5,
    parameter int ROW_SIZE   = 24,
    parameter int COL_SIZE   = 17,
    parameter int K          = 4,
    parameter int NUM_LEAVES = 64,
    parameter int NUM_QUERYS = ROW_SIZE * COL_SIZE,
    parameter int QA         = $clog2(NUM_QUERYS),
    parameter int LEAF_ADDRW = $clog2(NUM_LEAVES)
) (
    input  logic                             wb_clk_i,
    input  logic                             rst_n,
    input  logic                             wbs_stb_i,
    input  logic                             wbs_cyc_i,
    input  logic                             wbs_we_i,
    input  logic [3:0]                       wbs_sel_i,
    input  logic [31:0]                      wbs_dat_i,
    input  logic [31:0]                      wbs_adr_i,
    output logic                             wbs_ack_o,
    output logic [31:0]                      wbs_dat_o,
    output logic                             wbs_mode,
    output logic                             wbs_debug,
    output logic                             wbs_qp_mem_csb0,
    output logic                             wbs_qp_mem_web0,
    output logic [QA-1:0]                    wbs_qp_mem_addr0,
    output logic [PATCH_SIZE*DATA_WIDTH-1:0] wbs_qp_mem_wpatch0,
    input  logic [PATCH_SIZE*DATA_WIDTH-1:0] wbs_qp_mem_rpatch0,
    output logic [LEAF_SIZE-1:0]             wbs_leaf_mem_csb0,
    output logic [LEAF_SIZE-1:0]             wbs_leaf_mem_web0,
    output logic [LEAF_ADDRW-1:0]            wbs_leaf_mem_addr0,
    output logic [63:0]                      wbs_leaf_mem_wleaf0,
    input  logic [64*LEAF_SIZE-1:0]          wbs_leaf_mem_rleaf0,
    output logic                             wbs_node_mem_web,
    output logic [31:0]                      wbs_node_mem_addr,
    output logic [31:0]                      wbs_node_mem_wdata,
    input  logic [31:0]                      wbs_node_mem_rdata
);

    localparam int PW = PATCH_SIZE * DATA_WIDTH;
    localparam int BW = $clog2(LEAF_SIZE);

    typedef enum logic [1:0] {S_IDLE, S_MEM, S_WAIT, S_ACK} state_t;
    typedef enum logic [1:0] {T_QP, T_LEAF, T_NODE, T_NONE} tgt_t;

    state_t                r_state;
    state_t                w_next;
    tgt_t                  r_tgt;
    logic                  r_we;
    logic                  r_hi;
    logic                  r_ack;
    logic [31:0]           r_dat_o;
    logic                  r_mode;
    logic                  r_debug;
    logic [31:0]           r_hold;
    logic [QA-1:0]         r_qp_addr;
    logic [PW-1:0]         r_qp_wpatch;
    logic [BW-1:0]         r_bank;
    logic [LEAF_ADDRW-1:0] r_leaf_addr;
    logic [63:0]           r_leaf_wdata;
`ifdef WBS_NODE_MEM_EN
    logic [31:0]           r_node_addr;
    logic [31:0]           r_node_wdata;
`endif

    logic                  w_req;
    logic [3:0]            w_region;
    logic [23:0]           w_off;
    logic                  w_is_node;
    logic                  w_is_mem;
    logic                  w_mem_cyc;
    logic [63:0]           w_qp_full;
    logic [63:0]           w_qp_ext;
    logic [63:0]           w_leaf_word;
    logic [31:0]           w_rd_data;
    logic                  w_unused;

    assign w_req     = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:28] == 4'h3);
    assign w_region  = wbs_adr_i[27:24];
    assign w_off     = wbs_adr_i[23:0];
`ifdef WBS_NODE_MEM_EN
    assign w_is_node = (w_region == 4'h4);
`else
    assign w_is_node = 1'b0;
`endif
    assign w_is_mem  = (w_region == 4'h1) || (w_region == 4'h2) || w_is_node;
    assign w_mem_cyc = (r_state == S_MEM);

    // Upper-half qp commit: upper data bits above the patch width are dropped.
    assign w_qp_full = {wbs_dat_i, r_hold};
    assign w_qp_ext  = {{(64 - PW){1'b0}}, wbs_qp_mem_rpatch0};

    assign w_unused = ^{wbs_sel_i, wbs_adr_i, wbs_node_mem_rdata, w_qp_full[63:PW], 1'(K)};

    // Leaf bank word selected by the latched bank index.
    always_comb begin
        w_leaf_word = '0;
        for (int b = 0; b < LEAF_SIZE; b++) begin
            if (r_bank == BW'(b)) w_leaf_word = wbs_leaf_mem_rleaf0[b*64 +: 64];
        end
    end

    // Read-data mux for the WAIT sample.
    always_comb begin
        w_rd_data = '0;
        case (r_tgt)
            T_QP:   w_rd_data = r_hi ? w_qp_ext[63:32] : w_qp_ext[31:0];
            T_LEAF: w_rd_data = r_hi ? w_leaf_word[63:32] : w_leaf_word[31:0];
`ifdef WBS_NODE_MEM_EN
            T_NODE: w_rd_data = wbs_node_mem_rdata;
`endif
            default: w_rd_data = '0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // FSM next state and memory strobes (strobes only ever active in MEM).
    always_comb begin
        w_next             = r_state;
        wbs_qp_mem_csb0    = 1'b1;
        wbs_qp_mem_web0    = 1'b1;
        wbs_leaf_mem_csb0  = '1;
        wbs_leaf_mem_web0  = '1;
        wbs_node_mem_web   = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_is_mem && !(wbs_we_i && !wbs_adr_i[0] && !w_is_node))
                        w_next = S_MEM;
                    else
                        w_next = S_ACK;
                end
            end
            S_MEM:   w_next = r_we ? S_ACK : S_WAIT;
            S_WAIT:  w_next = S_ACK;
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_mem_cyc && r_tgt == T_QP) begin
            wbs_qp_mem_csb0 = 1'b0;
            wbs_qp_mem_web0 = !r_we;
        end
        for (int b = 0; b < LEAF_SIZE; b++) begin
            if (w_mem_cyc && r_tgt == T_LEAF && r_bank == BW'(b)) begin
                wbs_leaf_mem_csb0[b] = 1'b0;
                wbs_leaf_mem_web0[b] = !r_we;
            end
        end
`ifdef WBS_NODE_MEM_EN
        if (w_mem_cyc && r_tgt == T_NODE) wbs_node_mem_web = !r_we;
`endif
    end

    // Request decode, register writes, target latch and read-data capture.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_ack        <= 1'b0;
            r_dat_o      <= '0;
            r_mode       <= 1'b0;
            r_debug      <= 1'b0;
            r_hold       <= '0;
            r_tgt        <= T_NONE;
            r_we         <= 1'b0;
            r_hi         <= 1'b0;
            r_qp_addr    <= '0;
            r_qp_wpatch  <= '0;
            r_bank       <= '0;
            r_leaf_addr  <= '0;
            r_leaf_wdata <= '0;
`ifdef WBS_NODE_MEM_EN
            r_node_addr  <= '0;
            r_node_wdata <= '0;
`endif
        end else begin
            r_ack <= (w_next == S_ACK);
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_we  <= wbs_we_i;
                        r_hi  <= wbs_adr_i[0];
                        r_tgt <= T_NONE;
                        case (w_region)
                            4'h0: begin
                                if (wbs_we_i) begin
                                    if (w_off == 24'd0)      r_mode  <= wbs_dat_i[0];
                                    else if (w_off == 24'd1) r_debug <= wbs_dat_i[0];
                                end else begin
                                    if (w_off == 24'd0)      r_dat_o <= {31'b0, r_mode};
                                    else if (w_off == 24'd1) r_dat_o <= {31'b0, r_debug};
                                    else                     r_dat_o <= '0;
                                end
                            end
                            4'h1: begin
                                r_tgt     <= T_QP;
                                r_qp_addr <= wbs_adr_i[QA:1];
                                if (wbs_we_i && !wbs_adr_i[0]) r_hold      <= wbs_dat_i;
                                if (wbs_we_i && wbs_adr_i[0])  r_qp_wpatch <= w_qp_full[PW-1:0];
                            end
                            4'h2: begin
                                r_tgt       <= T_LEAF;
                                r_bank      <= wbs_adr_i[BW:1];
                                r_leaf_addr <= wbs_adr_i[BW+LEAF_ADDRW:BW+1];
                                if (wbs_we_i && !wbs_adr_i[0]) r_hold       <= wbs_dat_i;
                                if (wbs_we_i && wbs_adr_i[0])  r_leaf_wdata <= {wbs_dat_i, r_hold};
                            end
`ifdef WBS_NODE_MEM_EN
                            4'h4: begin
                                r_tgt        <= T_NODE;
                                r_node_addr  <= {9'b0, wbs_adr_i[23:1]};
                                if (wbs_we_i) r_node_wdata <= wbs_dat_i;
                            end
`endif
                            default: begin
                                if (!wbs_we_i) r_dat_o <= '0;
                            end
                        endcase
                    end
                end
                S_WAIT:  r_dat_o <= w_rd_data;
                default: ;
            endcase
        end
    end

    assign wbs_ack_o           = r_ack;
    assign wbs_dat_o           = r_dat_o;
    assign wbs_mode            = r_mode;
    assign wbs_debug           = r_debug;
    assign wbs_qp_mem_addr0    = r_qp_addr;
    assign wbs_qp_mem_wpatch0  = r_qp_wpatch;
    assign wbs_leaf_mem_addr0  = r_leaf_addr;
    assign wbs_leaf_mem_wleaf0 = r_leaf_wdata;
`ifdef WBS_NODE_MEM_EN
    assign wbs_node_mem_addr   = r_node_addr;
    assign wbs_node_mem_wdata  = r_node_wdata;
`else
    assign wbs_node_mem_addr   = '0;
    assign wbs_node_mem_wdata  = '0;
`endif

endmodule

// File: tb/tb_wbs_ctrl.sv
// Self-checking bench for wbs_ctrl: one task per scenario, expected results
// pushed to a scoreboard queue when a transaction is issued and popped at ack.
module tb_wbs_ctrl;

    localparam int PW  = 55;
    localparam int LS  = 8;
    localparam int QA  = 9;
    localparam int LAW = 6;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]      sel = 4'hF;
    logic [31:0]     dat_i = '0, adr = '0;
    logic            wbs_ack_o;
    logic [31:0]     wbs_dat_o;
    logic            wbs_mode, wbs_debug;
    logic            qp_csb, qp_web;
    logic [QA-1:0]   qp_addr;
    logic [PW-1:0]   qp_wpatch;
    logic [PW-1:0]   qp_rpatch = '0;
    logic [LS-1:0]   leaf_csb, leaf_web;
    logic [LAW-1:0]  leaf_addr;
    logic [63:0]     leaf_wleaf;
    logic [64*LS-1:0] leaf_rleaf = '0;
    logic            node_web;
    logic [31:0]     node_addr, node_wdata;
    logic [31:0]     node_rdata = '0;

    always #5 clk = ~clk;

    wbs_ctrl dut (
        .wb_clk_i(clk), .rst_n(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_dat_i(dat_i), .wbs_adr_i(adr),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .wbs_mode(wbs_mode), .wbs_debug(wbs_debug),
        .wbs_qp_mem_csb0(qp_csb), .wbs_qp_mem_web0(qp_web),
        .wbs_qp_mem_addr0(qp_addr), .wbs_qp_mem_wpatch0(qp_wpatch),
        .wbs_qp_mem_rpatch0(qp_rpatch),
        .wbs_leaf_mem_csb0(leaf_csb), .wbs_leaf_mem_web0(leaf_web),
        .wbs_leaf_mem_addr0(leaf_addr), .wbs_leaf_mem_wleaf0(leaf_wleaf),
        .wbs_leaf_mem_rleaf0(leaf_rleaf),
        .wbs_node_mem_web(node_web), .wbs_node_mem_addr(node_addr),
        .wbs_node_mem_wdata(node_wdata), .wbs_node_mem_rdata(node_rdata)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        int          lat;
        bit          chk_data;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_cs;
        int          exp_wr;
        int          exp_addr;
        int          exp_bank;
    } op_t;

    // Strobe monitor: counts memory strobes and captures what was presented.
    int              qp_cs_cnt = 0, qp_wr_cnt = 0;
    int              leaf_cs_cnt = 0, leaf_wr_cnt = 0, node_wr_cnt = 0;
    logic [QA-1:0]   cap_qp_addr = '0;
    logic [PW-1:0]   cap_wpatch = '0;
    logic [LS-1:0]   cap_leaf_csb = '1, cap_leaf_web = '1;
    logic [LAW-1:0]  cap_leaf_addr = '0;
    logic [63:0]     cap_wleaf = '0;
    logic [31:0]     cap_node_addr = '0, cap_node_wdata = '0;

    always @(negedge clk) begin
        if (!qp_csb) begin
            qp_cs_cnt   <= qp_cs_cnt + 1;
            cap_qp_addr <= qp_addr;
        end
        if (!qp_csb && !qp_web) begin
            qp_wr_cnt  <= qp_wr_cnt + 1;
            cap_wpatch <= qp_wpatch;
        end
        if (leaf_csb != '1) begin
            leaf_cs_cnt   <= leaf_cs_cnt + 1;
            cap_leaf_csb  <= leaf_csb;
            cap_leaf_addr <= leaf_addr;
        end
        if (leaf_web != '1) begin
            leaf_wr_cnt  <= leaf_wr_cnt + 1;
            cap_leaf_web <= leaf_web;
            cap_wleaf    <= leaf_wleaf;
        end
        if (!node_web) begin
            node_wr_cnt    <= node_wr_cnt + 1;
            cap_node_addr  <= node_addr;
            cap_node_wdata <= node_wdata;
        end
    end

    // One Wishbone transaction; returns read data and cycles to ack.
    task automatic wb_cycle(input logic [31:0] a, input logic w, input logic [31:0] d,
                            output logic [31:0] rd, output int lat);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!wbs_ack_o && lat < 20);
        rd = wbs_dat_o;
        checks++;
        if (!wbs_ack_o) begin
            errors++;
            $display("FAIL ack_timeout adr=%h: no ack after %0d cycles", a, lat);
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({wbs_ack_o, wbs_mode, wbs_debug} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl ack/mode/debug=%b expected 000", {wbs_ack_o, wbs_mode, wbs_debug});
        end
        checks++;
        if (wbs_dat_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_dat_o got %h expected 0", wbs_dat_o);
        end
        checks++;
        if ({qp_csb, qp_web, leaf_csb, leaf_web, node_web} !== {2'b11, {LS{1'b1}}, {LS{1'b1}}, 1'b1}) begin
            errors++;
            $display("FAIL reset_strobes qp=%b%b leaf_csb=%b leaf_web=%b node_web=%b expected all 1",
                     qp_csb, qp_web, leaf_csb, leaf_web, node_web);
        end
        checks++;
        if ({qp_addr, qp_wpatch, leaf_addr, leaf_wleaf, node_addr, node_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_addr_data qp_addr=%h wpatch=%h leaf_addr=%h wleaf=%h node=%h/%h expected 0",
                     qp_addr, qp_wpatch, leaf_addr, leaf_wleaf, node_addr, node_wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Register writes held back-to-back: debug=1, mode=1, debug=0.
    task automatic test_back_to_back_regs();
        logic [31:0] a_tab [3] = '{32'h3000_0001, 32'h3000_0000, 32'h3000_0001};
        logic [31:0] d_tab [3] = '{32'h1, 32'hFFFF_FFFF, 32'h0};
        logic [1:0]  md_tab[3] = '{2'b01, 2'b11, 2'b10};
        int          n;
        logic [31:0] rd;
        int          lat;
        exp_t        e;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = a_tab[0]; dat_i = d_tab[0];
        for (int i = 0; i < 3; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!wbs_ack_o && n < 20);
            checks++;
            if (n !== ((i == 0) ? 1 : 2)) begin
                errors++;
                $display("FAIL b2b_ack_spacing[%0d] got %0d cycles expected %0d", i, n, (i == 0) ? 1 : 2);
            end
            checks++;
            if ({wbs_mode, wbs_debug} !== md_tab[i]) begin
                errors++;
                $display("FAIL b2b_mode_debug[%0d] got %b expected %b", i, {wbs_mode, wbs_debug}, md_tab[i]);
            end
            if (i < 2) begin
                adr = a_tab[i+1]; dat_i = d_tab[i+1];
            end else begin
                stb = 1'b0; cyc = 1'b0; we = 1'b0;
            end
        end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{data: (i == 1) ? 32'h0 : 32'h1, lat: 1, chk_data: 1'b1});
            wb_cycle((i == 1) ? 32'h3000_0001 : ((i == 0) ? 32'h3000_0000 : 32'h3000_0007), 1'b0, '0, rd, lat);
            e = exp_q.pop_front();
            if (i == 2) e.data = 32'h0;
            checks++;
            if (rd !== e.data || lat !== e.lat) begin
                errors++;
                $display("FAIL reg_read[%0d] got %h/%0d cycles expected %h/%0d", i, rd, lat, e.data, e.lat);
            end
        end
    endtask

    task automatic test_qp();
        op_t ops[4];
        logic [31:0] rd;
        int lat, cs0, wr0;
        exp_t e;
        ops[0] = '{32'h3100_0002, 1'b0, 32'h0,         32'hDEAD_BEEF, 3, 1, 0, 1, 0};
        ops[1] = '{32'h3100_0003, 1'b0, 32'h0,         32'h0000_1010, 3, 1, 0, 1, 0};
        ops[2] = '{32'h3100_0004, 1'b1, 32'h0123_4567, 32'h0,         1, 0, 0, 0, 0};
        ops[3] = '{32'h3100_0005, 1'b1, 32'h000B_CDEF, 32'h0,         2, 1, 1, 2, 0};
        qp_rpatch = 55'h00_1010_DEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            cs0 = qp_cs_cnt; wr0 = qp_wr_cnt;
            exp_q.push_back('{data: ops[i].exp_data, lat: ops[i].exp_lat, chk_data: !ops[i].we});
            wb_cycle(ops[i].adr, ops[i].we, ops[i].dat, rd, lat);
            e = exp_q.pop_front();
            checks++;
            if (lat !== e.lat || (e.chk_data && rd !== e.data)) begin
                errors++;
                $display("FAIL qp_op[%0d] got %h/%0d cycles expected %h/%0d", i, rd, lat, e.data, e.lat);
            end
            checks++;
            if (qp_cs_cnt - cs0 !== ops[i].exp_cs || qp_wr_cnt - wr0 !== ops[i].exp_wr) begin
                errors++;
                $display("FAIL qp_strobes[%0d] got csb %0d web %0d expected %0d %0d",
                         i, qp_cs_cnt - cs0, qp_wr_cnt - wr0, ops[i].exp_cs, ops[i].exp_wr);
            end
            if (ops[i].exp_cs == 1) begin
                checks++;
                if (int'(cap_qp_addr) !== ops[i].exp_addr) begin
                    errors++;
                    $display("FAIL qp_addr[%0d] got %0d expected %0d", i, cap_qp_addr, ops[i].exp_addr);
                end
            end
        end
        checks++;
        if (cap_wpatch !== 55'h0B_CDEF_0123_4567) begin
            errors++;
            $display("FAIL qp_wpatch got %h expected %h", cap_wpatch, 55'h0B_CDEF_0123_4567);
        end
    endtask

    task automatic test_leaf();
        op_t ops[5];
        logic [31:0] rd;
        int lat, cs0, wr0;
        exp_t e;
        for (int b = 0; b < LS; b++) leaf_rleaf[b*64 +: 64] = {32'hC0DE_0000 + 32'(b), 32'h0BAD_0000 + 32'(b)};
        leaf_rleaf[7*64 +: 64] = 64'h1100_1010_DEAD_BEEF;
        ops[0] = '{32'h3200_000E, 1'b0, 32'h0,         32'hDEAD_BEEF, 3, 1, 0, 0, 7};
        ops[1] = '{32'h3200_000F, 1'b0, 32'h0,         32'h1100_1010, 3, 1, 0, 0, 7};
        ops[2] = '{32'h3200_0030, 1'b0, 32'h0,         32'h0BAD_0000, 3, 1, 0, 3, 0};
        ops[3] = '{32'h3200_0006, 1'b1, 32'h7654_3210, 32'h0,         1, 0, 0, 0, 3};
        ops[4] = '{32'h3200_0007, 1'b1, 32'hFEDC_BA98, 32'h0,         2, 1, 1, 0, 3};
        for (int i = 0; i < 5; i++) begin
            cs0 = leaf_cs_cnt; wr0 = leaf_wr_cnt;
            exp_q.push_back('{data: ops[i].exp_data, lat: ops[i].exp_lat, chk_data: !ops[i].we});
            wb_cycle(ops[i].adr, ops[i].we, ops[i].dat, rd, lat);
            e = exp_q.pop_front();
            checks++;
            if (lat !== e.lat || (e.chk_data && rd !== e.data)) begin
                errors++;
                $display("FAIL leaf_op[%0d] got %h/%0d cycles expected %h/%0d", i, rd, lat, e.data, e.lat);
            end
            checks++;
            if (leaf_cs_cnt - cs0 !== ops[i].exp_cs || leaf_wr_cnt - wr0 !== ops[i].exp_wr) begin
                errors++;
                $display("FAIL leaf_strobes[%0d] got csb %0d web %0d expected %0d %0d",
                         i, leaf_cs_cnt - cs0, leaf_wr_cnt - wr0, ops[i].exp_cs, ops[i].exp_wr);
            end
            if (ops[i].exp_cs == 1) begin
                checks++;
                if (cap_leaf_csb !== ~(8'b1 << ops[i].exp_bank) || int'(cap_leaf_addr) !== ops[i].exp_addr) begin
                    errors++;
                    $display("FAIL leaf_select[%0d] got csb %b addr %0d expected %b %0d", i, cap_leaf_csb,
                             cap_leaf_addr, ~(8'b1 << ops[i].exp_bank), ops[i].exp_addr);
                end
            end
        end
        checks++;
        if (cap_wleaf !== 64'hFEDC_BA98_7654_3210 || cap_leaf_web !== 8'hF7) begin
            errors++;
            $display("FAIL leaf_commit got wleaf %h web %b expected %h %b",
                     cap_wleaf, cap_leaf_web, 64'hFEDC_BA98_7654_3210, 8'hF7);
        end
    endtask

    task automatic test_node();
        logic [31:0] rd;
        int lat, wr0;
        exp_t e;
        node_rdata = 32'h0000_0007;
        wr0 = node_wr_cnt;
`ifdef WBS_NODE_MEM_EN
        exp_q.push_back('{data: 32'h0, lat: 2, chk_data: 1'b0});
`else
        exp_q.push_back('{data: 32'h0, lat: 1, chk_data: 1'b0});
`endif
        wb_cycle(32'h3400_0002, 1'b1, {10'b0, 11'd55, 11'd1}, rd, lat);
        e = exp_q.pop_front();
        checks++;
        if (lat !== e.lat) begin
            errors++;
            $display("FAIL node_write_latency got %0d expected %0d", lat, e.lat);
        end
`ifdef WBS_NODE_MEM_EN
        checks++;
        if (node_wr_cnt - wr0 !== 1 || cap_node_addr !== 32'h1 || cap_node_wdata !== 32'h0001_B801) begin
            errors++;
            $display("FAIL node_write got %0d strobes addr %h data %h expected 1 %h %h",
                     node_wr_cnt - wr0, cap_node_addr, cap_node_wdata, 32'h1, 32'h0001_B801);
        end
        exp_q.push_back('{data: 32'h7, lat: 3, chk_data: 1'b1});
`else
        checks++;
        if (node_wr_cnt - wr0 !== 0 || node_addr !== 32'h0 || node_wdata !== 32'h0) begin
            errors++;
            $display("FAIL node_unmapped got %0d strobes addr %h data %h expected 0 0 0",
                     node_wr_cnt - wr0, node_addr, node_wdata);
        end
        exp_q.push_back('{data: 32'h0, lat: 1, chk_data: 1'b1});
`endif
        wb_cycle(32'h3400_0002, 1'b0, '0, rd, lat);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e.data || lat !== e.lat) begin
            errors++;
            $display("FAIL node_read got %h/%0d cycles expected %h/%0d", rd, lat, e.data, e.lat);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] a_tab[3] = '{32'h3300_0010, 32'h3500_0000, 32'h3F00_0001};
        logic [31:0] rd;
        int lat, acks;
        exp_t e;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h2000_0000;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (wbs_ack_o) acks++;
        end
        stb = 1'b0; cyc = 1'b0;
        checks++;
        if (acks !== 0) begin
            errors++;
            $display("FAIL out_of_region_ack got %0d acks expected 0", acks);
        end
        wb_cycle(32'h3300_0000, 1'b1, 32'hFFFF_FFFF, rd, lat);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{data: 32'h0, lat: 1, chk_data: 1'b1});
            wb_cycle(a_tab[i], 1'b0, '0, rd, lat);
            e = exp_q.pop_front();
            checks++;
            if (rd !== e.data || lat !== e.lat) begin
                errors++;
                $display("FAIL unmapped_read[%0d] got %h/%0d cycles expected %h/%0d", i, rd, lat, e.data, e.lat);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] rd;
        int lat, acks;
        exp_t e;
        wb_cycle(32'h3000_0000, 1'b1, 32'h1, rd, lat);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h3100_0002;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({wbs_ack_o, qp_csb, qp_web, wbs_mode} !== 4'b0110 || wbs_dat_o !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset ack/csb/web/mode=%b dat_o=%h expected 0110 0",
                     {wbs_ack_o, qp_csb, qp_web, wbs_mode}, wbs_dat_o);
        end
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (wbs_ack_o) acks++;
        end
        stb = 1'b0; cyc = 1'b0;
        rst_n = 1'b1;
        checks++;
        if (acks !== 0) begin
            errors++;
            $display("FAIL mid_reset_ack got %0d acks expected 0", acks);
        end
        exp_q.push_back('{data: 32'hDEAD_BEEF, lat: 3, chk_data: 1'b1});
        wb_cycle(32'h3100_0002, 1'b0, '0, rd, lat);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e.data || lat !== e.lat) begin
            errors++;
            $display("FAIL post_reset_read got %h/%0d cycles expected %h/%0d", rd, lat, e.data, e.lat);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back_regs();
        test_qp();
        test_leaf();
        test_node();
        test_unmapped();
        test_mid_reset();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
